// File: rtl/serial_pkg.sv
// Shared definitions for the serial receive path: state encodings, data width
// and the majority vote used when sampling is filtered.
package serial_pkg;

  localparam int STATE_SIZE = 3;
  localparam int DATA_BITS  = 8;

  typedef enum logic [STATE_SIZE-1:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA      = 3'd2,
    STOP_BIT  = 3'd3,
    RECOVER   = 3'd4
  } rx_state_t;

  function automatic logic majority3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/serial_sync_2ff.sv
// Two-flop synchroniser for an asynchronous input that idles high; both
// stages reset to 1 so a reset never looks like a falling edge.
module serial_sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/serial_rx.sv
// 8N1 UART receiver with mid-bit sampling, framing-error detection and break
// recovery. Define SERIAL_RX_MAJORITY_EN to vote each sample over three cycles.
module serial_rx
  import serial_pkg::*;
#(
  parameter int CLK_PER_BIT = 50,
  parameter int CTR_SIZE    = $clog2(CLK_PER_BIT)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 new_data,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int IDX_SIZE = $clog2(DATA_BITS);
  localparam logic [CTR_SIZE-1:0] HALF_LAST = CTR_SIZE'(CLK_PER_BIT / 2 - 1);
  localparam logic [CTR_SIZE-1:0] BIT_LAST  = CTR_SIZE'(CLK_PER_BIT - 1);
  localparam logic [IDX_SIZE-1:0] IDX_LAST  = IDX_SIZE'(DATA_BITS - 1);

  rx_state_t state, state_nxt;

  logic                 rx_sync;
  logic                 sample_bit;
  logic [CTR_SIZE-1:0]  ctr, ctr_nxt;
  logic [IDX_SIZE-1:0]  bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic [DATA_BITS-1:0] data_nxt;
  logic                 new_data_nxt, frame_err_nxt, busy_nxt;

  serial_sync_2ff u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (rx),
    .sync_out (rx_sync)
  );

`ifdef SERIAL_RX_MAJORITY_EN
  logic [1:0] rx_hist;

  always_ff @(posedge clk) begin
    if (rst) rx_hist <= 2'b11;
    else     rx_hist <= {rx_hist[0], rx_sync};
  end

  assign sample_bit = majority3({rx_hist, rx_sync});
`else
  assign sample_bit = rx_sync;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // A high start sample is treated as a glitch; a low stop sample parks in
  // RECOVER so a held-low break cannot start another frame.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rx_sync) state_nxt = START_BIT;
      START_BIT: if (ctr == HALF_LAST) state_nxt = sample_bit ? IDLE : DATA;
      DATA:      if (ctr == BIT_LAST && bit_idx == IDX_LAST) state_nxt = STOP_BIT;
      STOP_BIT:  if (ctr == BIT_LAST) state_nxt = sample_bit ? IDLE : RECOVER;
      RECOVER:   if (rx_sync) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ctr_nxt       = '0;
    bit_idx_nxt   = bit_idx;
    shift_nxt     = shift;
    data_nxt      = data;
    new_data_nxt  = 1'b0;
    frame_err_nxt = 1'b0;
    busy_nxt      = (state_nxt != IDLE);
    case (state)
      START_BIT: begin
        if (ctr != HALF_LAST) ctr_nxt = ctr + 1'b1;
      end
      DATA: begin
        if (ctr == BIT_LAST) begin
          shift_nxt[bit_idx] = sample_bit;
          bit_idx_nxt        = bit_idx + 1'b1;
        end else begin
          ctr_nxt = ctr + 1'b1;
        end
      end
      STOP_BIT: begin
        if (ctr == BIT_LAST) begin
          if (sample_bit) begin
            data_nxt     = shift;
            new_data_nxt = 1'b1;
          end else begin
            frame_err_nxt = 1'b1;
          end
        end else begin
          ctr_nxt = ctr + 1'b1;
        end
      end
      default: bit_idx_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctr       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      new_data  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      ctr       <= ctr_nxt;
      bit_idx   <= bit_idx_nxt;
      shift     <= shift_nxt;
      data      <= data_nxt;
      new_data  <= new_data_nxt;
      frame_err <= frame_err_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_serial_rx.sv
// Self-checking bench for serial_rx: drives 8N1 frames on rx and compares the
// received bytes and pulses against an expected-byte queue built from the frames.
module tb_serial_rx;

  localparam int CPB  = 50;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data;
  logic       new_data, frame_err, busy;

  int assertCount = 0;
  int failCount   = 0;
  int cyc         = 0;
  int ndCount     = 0;
  int feCount     = 0;
  int ndLastCyc   = -1;
  int wideCount   = 0;
  int bothHigh    = 0;
  int startCyc    = 0;
  logic ndPrev = 1'b0;
  logic fePrev = 1'b0;

  logic [7:0] rxQ[$];
  logic [7:0] expQ[$];

  serial_rx #(.CLK_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .new_data  (new_data),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Collects every received byte and the pulse shape of both strobes.
  always @(negedge clk) begin
    if (new_data && !ndPrev) ndLastCyc = cyc;
    if (new_data) begin
      ndCount++;
      rxQ.push_back(data);
    end
    if (frame_err) feCount++;
    if ((new_data && ndPrev) || (frame_err && fePrev)) wideCount++;
    if (new_data && frame_err) bothHigh++;
    ndPrev = new_data;
    fePrev = frame_err;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed no end of test, required finish within 100000 cycles");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one frame (start, 8 data bits LSB first, stop) one cycle per step,
  // optionally inverting the mid-bit cycle of each data bit; stops early after maxCycles.
  task automatic applyStimulus(input logic [7:0] b, input logic stopBit,
                               input bit glitch, input int maxCycles);
    logic [9:0] frame;
    logic       v;
    int         n;
    frame    = {stopBit, b, 1'b0};
    n        = 0;
    startCyc = cyc;
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        if (n >= maxCycles) return;
        v = frame[k];
        if (glitch && k >= 1 && k <= 8 && j == HALF) v = ~v;
        rx = v;
        n++;
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(input int cycles);
    rx = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic drainQueues(input string tag);
    checkOutput({tag, "_count"}, rxQ.size(), expQ.size());
    while (rxQ.size() > 0 && expQ.size() > 0)
      checkOutput({tag, "_byte"}, rxQ.pop_front(), expQ.pop_front());
    rxQ.delete();
    expQ.delete();
  endtask

  initial begin
    int         nd0, fe0, expRise, gap;
    logic [7:0] b;
    logic [7:0] exp96;
    logic [7:0] b2b[3];
    b2b = '{8'h00, 8'hFF, 8'h3C};

    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_data", data, 8'h00);
    checkOutput("reset_new_data", new_data, 1'b0);
    checkOutput("reset_frame_err", frame_err, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);
    rst = 1'b0;
    idle(CPB);

    fe0 = feCount;
    expQ.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b1, 1'b0, 10 * CPB);
    expRise = startCyc + 3 + HALF + 9 * CPB;
    idle(CPB);
    checkOutput("a5_data", data, 8'hA5);
    checkOutput("a5_latency",
                (ndLastCyc >= expRise - 1 && ndLastCyc <= expRise + 1) ? expRise : ndLastCyc,
                expRise);
    checkOutput("a5_frame_err", feCount - fe0, 0);
    drainQueues("a5");

    for (int i = 0; i < 3; i++) begin
      expQ.push_back(b2b[i]);
      applyStimulus(b2b[i], 1'b1, 1'b0, 10 * CPB);
    end
    idle(CPB);
    drainQueues("b2b");
    checkOutput("b2b_last_data", data, 8'h3C);

    nd0 = ndCount;
    fe0 = feCount;
    applyStimulus(8'h55, 1'b0, 1'b0, 10 * CPB);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    checkOutput("ferr_pulses", feCount - fe0, 1);
    checkOutput("ferr_no_new_data", ndCount - nd0, 0);
    checkOutput("ferr_data_kept", data, 8'h3C);
    checkOutput("ferr_busy_held", busy, 1'b1);
    idle(6);
    checkOutput("ferr_busy_released", busy, 1'b0);
    idle(2 * CPB);
    checkOutput("ferr_single_pulse", feCount - fe0, 1);

    nd0 = ndCount;
    fe0 = feCount;
    rx  = 1'b0;
    repeat (10) @(negedge clk);
    checkOutput("glitch_busy_seen", busy, 1'b1);
    rx = 1'b1;
    repeat (19) @(negedge clk);
    checkOutput("glitch_busy_cleared", busy, 1'b0);
    idle(2 * CPB);
    checkOutput("glitch_no_new_data", ndCount - nd0, 0);
    checkOutput("glitch_no_frame_err", feCount - fe0, 0);

    nd0 = ndCount;
    fe0 = feCount;
    applyStimulus(8'hC3, 1'b1, 1'b0, 5 * CPB + HALF);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midrst_data", data, 8'h00);
    checkOutput("midrst_new_data", new_data, 1'b0);
    checkOutput("midrst_frame_err", frame_err, 1'b0);
    checkOutput("midrst_busy", busy, 1'b0);
    rst = 1'b0;
    idle(2 * CPB);
    checkOutput("midrst_no_pulse", (ndCount - nd0) + (feCount - fe0), 0);
    expQ.push_back(8'h12);
    applyStimulus(8'h12, 1'b1, 1'b0, 10 * CPB);
    idle(CPB);
    drainQueues("post_rst");
    checkOutput("post_rst_data", data, 8'h12);

    // A one-cycle inversion at every data mid-bit is outvoted only when filtering is built in.
`ifdef SERIAL_RX_MAJORITY_EN
    exp96 = 8'h96;
`else
    exp96 = 8'h69;
`endif
    expQ.push_back(exp96);
    applyStimulus(8'h96, 1'b1, 1'b1, 10 * CPB);
    idle(CPB);
    checkOutput("glitch96_data", data, exp96);
    drainQueues("glitch96");

    for (int i = 0; i < 8; i++) begin
      b   = 8'($urandom_range(0, 255));
      gap = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 2 * CPB));
      expQ.push_back(b);
      applyStimulus(b, 1'b1, 1'b0, 10 * CPB);
      idle(gap);
    end
    idle(CPB);
    drainQueues("rand");

    checkOutput("pulse_width_one_cycle", wideCount, 0);
    checkOutput("pulses_exclusive", bothHigh, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
Name: serial_rx

Overview:
- 8N1 UART receiver; the receive-side counterpart of the team's serial transmitter, at the same bit timing.
- Synchronises the asynchronous `rx` pin and detects the start bit.
- Samples each bit at mid-bit and presents a received byte with a one-cycle `new_data` strobe.
- Flags framing errors and does not re-trigger on a held-low line (break).

Parameters:
- CLK_PER_BIT, 50, clk cycles per serial bit; must be >= 4.
- CTR_SIZE, $clog2(CLK_PER_BIT), derived width of the bit-period counter; not overridden.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- rx  in  1  asynchronous serial line; idles high.
- data  out  8  last received byte, LSB first on the line; held until the next good byte.
- new_data  out  1  one-cycle pulse: `data` is valid and freshly updated.
- frame_err  out  1  one-cycle pulse: stop bit sampled low; `data` not updated.
- busy  out  1  high from start-bit detect until return to IDLE.

Behaviour:
- Reset values: data=8'h00, new_data=0, frame_err=0, busy=0, state=IDLE.
  - Synchroniser flops reset to 1, bit counter to 0, bit index to 0.
- Synchroniser: two flops rx -> rx_meta -> rx_sync; all logic uses rx_sync only.
- HALF = CLK_PER_BIT/2, integer division.
- All outputs are registered; new_data and frame_err are never high in the same cycle.
- State encoding is 3-bit: IDLE, START_BIT, DATA, STOP_BIT, RECOVER.
- IDLE:
  - busy=0, ctr=0, bit index=0.
  - rx_sync==0 -> START_BIT, busy=1 next cycle.
- START_BIT:
  - ctr increments each cycle.
  - At ctr==HALF-1: sample rx_sync.
  - Sample 0 -> DATA, ctr=0.
  - Sample 1 (glitch) -> IDLE silently, with no pulse.
- DATA:
  - ctr increments; at ctr==CLK_PER_BIT-1, sample into shift register bit[bit index], ctr=0, bit index+1.
  - After bit index 7 -> STOP_BIT; bit index wraps to 0.
- STOP_BIT: at ctr==CLK_PER_BIT-1, sample rx_sync.
  - Sample 1: data<=shift register, new_data=1 for one cycle, -> IDLE.
  - Sample 0: frame_err=1 for one cycle, data unchanged, -> RECOVER.
- RECOVER:
  - busy=1; wait until rx_sync==1, then -> IDLE.
  - A break therefore yields exactly one frame_err and no further frames.
- Latency:
  - Let edge E be the first clk edge at which rx_sync==0 is registered into state.
  - new_data rises HALF + 9*CLK_PER_BIT cycles after E; for 50, that is 475.
  - Back-to-back frames with zero idle are accepted: IDLE sees the next start immediately after the stop sample.
- Reset mid-frame: immediate return to IDLE, outputs to reset values, and no pulse.
- Unknown state encoding -> IDLE.

Optional Feature:
- Macro SERIAL_RX_MAJORITY_EN.
- Defined:
  - Keep a 3-bit history of rx_sync.
  - Every sample (start, data, stop) uses the majority of the three most recent rx_sync values at the sample cycle.
  - Rejects single-cycle glitches near mid-bit; latency unchanged.
- Undefined: single sample of rx_sync; no history register.

Decomposition:
- Package serial_pkg:
  - STATE_SIZE=3 and the five state encodings.
  - DATA_BITS=8.
  - Shared between serial_rx and a future framer.
- Sub-module serial_sync_2ff: the 2-flop synchroniser, reset-to-1, reusable for other async inputs.
- Everything else stays in serial_rx.

Test Plan:
- Send 8'hA5 at CLK_PER_BIT=50, 1 stop bit.
  - Expect: data==8'hA5, new_data high exactly 1 cycle, 475 cycles (±1) after start detect.
  - Expect: frame_err never high.
- Three frames 8'h00, 8'hFF, 8'h3C back-to-back with zero idle -> three new_data pulses, in order, data values matching.
- Send 8'h55 with the stop bit forced low.
  - Expect: one frame_err pulse, data retains the previous value.
  - Expect: busy stays high until rx returns high, then goes to 0.
- 10-cycle low glitch on idle rx -> no new_data, no frame_err, busy returns to 0 before cycle 30.
- Assert rst during bit 4 of 8'hC3 -> outputs at reset values the next cycle; a following 8'h12 frame is received correctly.
- With SERIAL_RX_MAJORITY_EN, a 1-cycle inverted glitch at mid-bit of every data bit of 8'h96 -> data==8'h96.
  - Without the macro, same stimulus -> data!=8'h96.
